regfile_mp: RTL

//  Parametrised successor to the 8x16 single-read-port register file used by the lab datapath.
//  - WIDTH x DEPTH storage.
//  - One synchronous write port and two combinational read ports (A and B), so a datapath can

---
 rtl/regfile_mp.sv | 139 +++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// RegfileMp (module regfile_mp)
// Purpose : WIDTH x DEPTH register file with one synchronous write port, two
//           independent combinational read ports (A and B) and a hardware
//           clear sequencer that zeroes every register over DEPTH cycles.
//           A sticky flag records any write discarded because of a sweep.
// Ports   : clk         rising-edge clock
//           reset       asynchronous active-high reset
//           data_in     write data
//           writenum    write register index
//           write       write enable (sampled at posedge clk)
//           readnum_a   read port A index
//           readnum_b   read port B index
//           data_out_a  contents of reg[readnum_a] (combinational)
//           data_out_b  contents of reg[readnum_b] (combinational)
//           clear       request a clear sweep (sampled at posedge clk)
//           busy        high while the sweep is running
//           done        one-cycle pulse after the last register is cleared
//           wr_dropped  sticky flag: a write was discarded due to a sweep
// Config  : define REGFILE_BYPASS_EN to forward an accepted same-cycle write
//           straight to a read port whose index matches writenum.
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    writenum,
  input  logic             write,
  input  logic [AW-1:0]    readnum_a,
  input  logic [AW-1:0]    readnum_b,
  output logic [WIDTH-1:0] data_out_a,
  output logic [WIDTH-1:0] data_out_b,
  input  logic             clear,
  output logic             busy,
  output logic             done,
  output logic             wr_dropped
);

  typedef enum logic {
    S_IDLE,
    S_SWEEP
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [AW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_regs [DEPTH];
  logic             r_done;
  logic             r_dropped;

  logic             w_wrAccept;
  logic             w_wrDrop;
  logic             w_lastSweep;

  // A write lands only when idle and no clear competes with it; any other
  // write request is a dropped write.
  assign w_wrAccept  = (r_state == S_IDLE) && write && !clear;
  assign w_wrDrop    = write && ((r_state == S_SWEEP) || clear);
  assign w_lastSweep = (r_state == S_SWEEP) && (r_cnt == AW'(DEPTH - 1));

  // State register for the clear sequencer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: clear starts a sweep from idle only; a clear seen while
  // sweeping is ignored so the sweep never restarts.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (clear) w_nextState = S_SWEEP;
      S_SWEEP: if (w_lastSweep) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Sweep counter starts at zero on entry and is forced back to zero on exit
  // so the next sweep always begins at register 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == S_SWEEP) begin
      r_cnt <= w_lastSweep ? '0 : r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  // Storage: the sweep zeroes one register per edge; otherwise an accepted
  // write updates the addressed register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (r_state == S_SWEEP) begin
      r_regs[r_cnt] <= '0;
    end else if (w_wrAccept) begin
      r_regs[writenum] <= data_in;
    end
  end

  // done pulses for the single cycle after the final register is cleared;
  // wr_dropped is sticky until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done    <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_done <= w_lastSweep;
      if (w_wrDrop) begin
        r_dropped <= 1'b1;
      end
    end
  end

  assign busy       = (r_state == S_SWEEP);
  assign done       = r_done;
  assign wr_dropped = r_dropped;

`ifdef REGFILE_BYPASS_EN
  // Write-through forwarding: only accepted writes are forwarded.
  assign data_out_a = (w_wrAccept && (writenum == readnum_a)) ? data_in : r_regs[readnum_a];
  assign data_out_b = (w_wrAccept && (writenum == readnum_b)) ? data_in : r_regs[readnum_b];
`else
  assign data_out_a = r_regs[readnum_a];
  assign data_out_b = r_regs[readnum_b];
`endif

endmodule
